// File: rtl/pixel_write_arbiter_if.sv
// rtl/pixel_write_arbiter_if.sv - drawer/adapter bundle for the framebuffer write arbiter
//
// Purpose: groups the clear request, the three requester write channels and
// the VGA adapter write port that the arbiter sits between.
// Ports (signals):
//   clear_req             start a full-screen black sweep
//   req_valid[2:0]        per-requester write request (0 user, 1 enemy, 2 bullets)
//   req_x/req_y/req_colour packed {r2,r1,r0} coordinates and colour
//   req_ready[2:0]        one-hot grant back to the requesters
//   x/y/colour/plot       registered adapter write port
//   busy/clear_done/range_err status
// modport master: drawers + adapter side; modport slave: the arbiter.
interface pixel_write_arbiter_if;
  logic        clear_req;
  logic [2:0]  req_valid;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  req_ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        clear_done;
  logic        range_err;

  modport master (
    output clear_req, req_valid, req_x, req_y, req_colour,
    input  req_ready, x, y, colour, plot, busy, clear_done, range_err
  );

  modport slave (
    input  clear_req, req_valid, req_x, req_y, req_colour,
    output req_ready, x, y, colour, plot, busy, clear_done, range_err
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin pixel write arbiter with full-screen clear sweep
//
// Purpose: shares the single 160x120x3 framebuffer write port between the user
// ship, enemy ship and bullet drawers, and owns the black clear sweep.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     pixel_write_arbiter_if.slave (requests, grants, adapter port, status)
module pixel_write_arbiter (
  input  logic                   clk,
  input  logic                   resetn,
  pixel_write_arbiter_if.slave   bus
);

  typedef enum logic {ARB, CLEAR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  sx_q, sx_d;
  logic [6:0]  sy_q, sy_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [2:0]  gnt;
  logic [1:0]  sel;
  logic        found;
  logic [2:0]  idx;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_c;

  // Round-robin search starting at ptr_q; clear_req suppresses all grants so
  // the sweep takes priority in the cycle it is requested.
  always_comb begin
    gnt   = '0;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    if (state_q == ARB && !bus.clear_req) begin
      for (int k = 0; k < 3; k++) begin
        idx = {1'b0, ptr_q} + 3'(k);
        if (idx > 3'd2) idx = idx - 3'd3;
        if (!found && bus.req_valid[idx[1:0]]) begin
          gnt[idx[1:0]] = 1'b1;
          sel           = idx[1:0];
          found         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_x = bus.req_x[23:16];
    sel_y = bus.req_y[20:14];
    sel_c = bus.req_colour[8:6];
    case (sel)
      2'd0: begin
        sel_x = bus.req_x[7:0];
        sel_y = bus.req_y[6:0];
        sel_c = bus.req_colour[2:0];
      end
      2'd1: begin
        sel_x = bus.req_x[15:8];
        sel_y = bus.req_y[13:7];
        sel_c = bus.req_colour[5:3];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ARB: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
        end else if (found) begin
          ptr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          // Out-of-range writes are acknowledged but never reach the adapter.
          if (sel_x <= 8'd159 && sel_y <= 7'd119) begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_c;
            plot_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        x_d      = sx_q;
        y_d      = sy_q;
        colour_d = 3'b000;
        plot_d   = 1'b1;
        if (sx_q == 8'd159) begin
          sx_d = '0;
          if (sy_q == 7'd119) begin
            sy_d    = '0;
            done_d  = 1'b1;
            state_d = ARB;
          end else begin
            sy_d = sy_q + 7'd1;
          end
        end else begin
          sx_d = sx_q + 8'd1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.clear_done = done_q;
  assign bus.range_err  = err_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - directed self-checking bench for pixel_write_arbiter
module tb_pixel_write_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  pixel_write_arbiter_if bus ();

  pixel_write_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    bus.clear_req  = 1'b0;
    bus.req_valid  = 3'b000;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
    #23;
    vec_cnt++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done, bus.range_err} !== 22'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b err=%b exp all 0",
               bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done, bus.range_err);
    end
    vec_cnt++;
    if (bus.req_ready !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_ready got=%b exp=000", bus.req_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    int bad_pix = 0;
    int bad_rdy = 0;
    int bad_flg = 0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    vec_cnt++;
    if (bus.busy !== 1'b1 || bus.plot !== 1'b0) begin
      err_cnt++;
      $display("FAIL clear_start got busy=%b plot=%b exp busy=1 plot=0", bus.busy, bus.plot);
    end
    for (int i = 0; i < 19200; i++) begin
      if (bus.req_ready !== 3'b000) bad_rdy++;
      tick();
      if ({bus.plot, bus.x, bus.y, bus.colour} !== {1'b1, 8'(i % 160), 7'(i / 160), 3'b000}) bad_pix++;
      if (bus.clear_done !== (i == 19199) || bus.busy !== (i != 19199)) bad_flg++;
    end
    bus.req_valid = 3'b000;
    vec_cnt++;
    if (bad_pix !== 0) begin
      err_cnt++;
      $display("FAIL clear_pixels got %0d bad pixels exp 0", bad_pix);
    end
    vec_cnt++;
    if (bad_rdy !== 0) begin
      err_cnt++;
      $display("FAIL clear_ready got %0d cycles with grant exp 0", bad_rdy);
    end
    vec_cnt++;
    if (bad_flg !== 0) begin
      err_cnt++;
      $display("FAIL clear_done_busy got %0d bad cycles exp 0", bad_flg);
    end
    tick();
    vec_cnt++;
    if (bus.plot !== 1'b0 || bus.clear_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL clear_after got plot=%b done=%b exp 0 0", bus.plot, bus.clear_done);
    end
  endtask

  task automatic test_round_robin();
    int g;
    bus.req_x      = {8'd30, 8'd20, 8'd10};
    bus.req_y      = {7'd31, 7'd21, 7'd11};
    bus.req_colour = {3'd3, 3'd2, 3'd1};
    bus.req_valid  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      #1;
      vec_cnt++;
      if (bus.req_ready !== 3'(1 << g)) begin
        err_cnt++;
        $display("FAIL rr_grant[%0d] got=%b exp=%b", k, bus.req_ready, 3'(1 << g));
      end
      tick();
      vec_cnt++;
      if ({bus.plot, bus.x, bus.y, bus.colour} !== {1'b1, 8'(10 + 10 * g), 7'(11 + 10 * g), 3'(g + 1)}) begin
        err_cnt++;
        $display("FAIL rr_plot[%0d] got plot=%b (%0d,%0d) c=%0d exp plot=1 (%0d,%0d) c=%0d",
                 k, bus.plot, bus.x, bus.y, bus.colour, 10 + 10 * g, 11 + 10 * g, g + 1);
      end
    end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_single();
    bus.req_valid = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      vec_cnt++;
      if (bus.req_ready !== 3'b010) begin
        err_cnt++;
        $display("FAIL single_grant[%0d] got=%b exp=010", k, bus.req_ready);
      end
      tick();
      vec_cnt++;
      if ({bus.plot, bus.x, bus.y, bus.colour} !== {1'b1, 8'd20, 7'd21, 3'd2}) begin
        err_cnt++;
        $display("FAIL single_plot[%0d] got plot=%b (%0d,%0d) c=%0d exp plot=1 (20,21) c=2",
                 k, bus.plot, bus.x, bus.y, bus.colour);
      end
    end
    bus.req_valid = 3'b111;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 3'b100) begin
      err_cnt++;
      $display("FAIL single_ptr got=%b exp=100", bus.req_ready);
    end
    bus.req_valid = 3'b000;
    #1;
  endtask

  task automatic test_out_of_range();
    bus.req_valid = 3'b001;
    bus.req_x[7:0] = 8'd160;
    bus.req_y[6:0] = 7'd5;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 3'b001) begin
      err_cnt++;
      $display("FAIL oor_x_ready got=%b exp=001", bus.req_ready);
    end
    tick();
    vec_cnt++;
    if (bus.plot !== 1'b0 || bus.range_err !== 1'b1 || bus.x !== 8'd20) begin
      err_cnt++;
      $display("FAIL oor_x got plot=%b err=%b x=%0d exp plot=0 err=1 x=20", bus.plot, bus.range_err, bus.x);
    end
    bus.req_x[7:0] = 8'd10;
    bus.req_y[6:0] = 7'd120;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 3'b001) begin
      err_cnt++;
      $display("FAIL oor_y_ready got=%b exp=001", bus.req_ready);
    end
    tick();
    vec_cnt++;
    if (bus.plot !== 1'b0 || bus.range_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL oor_y got plot=%b err=%b exp plot=0 err=1", bus.plot, bus.range_err);
    end
    bus.req_x[7:0] = 8'd159;
    bus.req_y[6:0] = 7'd119;
    tick();
    vec_cnt++;
    if ({bus.plot, bus.x, bus.y, bus.range_err} !== {1'b1, 8'd159, 7'd119, 1'b1}) begin
      err_cnt++;
      $display("FAIL edge_pixel got plot=%b (%0d,%0d) err=%b exp plot=1 (159,119) err=1",
               bus.plot, bus.x, bus.y, bus.range_err);
    end
    bus.req_x[7:0] = 8'd10;
    bus.req_y[6:0] = 7'd10;
    tick();
    vec_cnt++;
    if ({bus.plot, bus.x, bus.y, bus.colour, bus.range_err} !== {1'b1, 8'd10, 7'd10, 3'd1, 1'b1}) begin
      err_cnt++;
      $display("FAIL oor_recover got plot=%b (%0d,%0d) c=%0d err=%b exp plot=1 (10,10) c=1 err=1",
               bus.plot, bus.x, bus.y, bus.colour, bus.range_err);
    end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_collision();
    int plots = 0;
    int dones = 0;
    int cyc   = 0;
    bus.req_valid = 3'b111;
    bus.clear_req = 1'b1;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 3'b000) begin
      err_cnt++;
      $display("FAIL coll_ready got=%b exp=000", bus.req_ready);
    end
    tick();
    bus.clear_req = 1'b0;
    vec_cnt++;
    if (bus.busy !== 1'b1 || bus.plot !== 1'b0) begin
      err_cnt++;
      $display("FAIL coll_start got busy=%b plot=%b exp busy=1 plot=0", bus.busy, bus.plot);
    end
    while (cyc < 20000 && dones == 0) begin
      bus.clear_req = (cyc == 3000);
      tick();
      cyc++;
      if (bus.plot === 1'b1) plots++;
      if (bus.clear_done === 1'b1) dones++;
    end
    bus.clear_req = 1'b0;
    #1;
    vec_cnt++;
    if (plots !== 19200 || dones !== 1) begin
      err_cnt++;
      $display("FAIL coll_count got plots=%0d dones=%0d exp 19200 1", plots, dones);
    end
    vec_cnt++;
    if (bus.req_ready !== 3'b010) begin
      err_cnt++;
      $display("FAIL coll_resume got=%b exp=010", bus.req_ready);
    end
    bus.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int plots = 0;
    int cyc   = 0;
    int bad   = 0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    while (plots < 5000 && cyc < 6000) begin
      tick();
      cyc++;
      if (bus.plot === 1'b1) plots++;
    end
    vec_cnt++;
    if (plots !== 5000) begin
      err_cnt++;
      $display("FAIL mid_reach got plots=%0d exp 5000", plots);
    end
    resetn = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    vec_cnt++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done, bus.range_err} !== 22'd0) begin
      err_cnt++;
      $display("FAIL mid_reset got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b err=%b exp all 0",
               bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.clear_done, bus.range_err);
    end
    vec_cnt++;
    if (bus.req_ready !== 3'b001) begin
      err_cnt++;
      $display("FAIL mid_reset_ready got=%b exp=001", bus.req_ready);
    end
    bus.req_valid = 3'b000;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.clear_done !== 1'b0 || bus.plot !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++;
      $display("FAIL mid_after got %0d bad cycles exp 0", bad);
    end
    bus.req_valid = 3'b001;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 3'b001) begin
      err_cnt++;
      $display("FAIL mid_arb got=%b exp=001", bus.req_ready);
    end
    bus.req_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_round_robin();
    test_single();
    test_out_of_range();
    test_collision();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
